// File: rtl/board_write_arbiter_pkg.sv
// Shared constants and types for the game-board write path.
// Holds board geometry, tile codes and the write-arbiter state encoding.
// Imported by the arbiter, its address generator and the game-writer interface.
package board_write_arbiter_pkg;

  localparam int BOARD_NUM_CELLS = 768;
  localparam int BOARD_ADDR_W    = 10;
  localparam int BOARD_DATA_W    = 4;
  localparam int BOARD_CNT_W     = 9;

  typedef enum logic [BOARD_DATA_W-1:0] {
    TILE_EMPTY  = 4'd0,
    TILE_WALL   = 4'd1,
    TILE_FOOD   = 4'd2,
    TILE_PACMAN = 4'd3,
    TILE_GHOST  = 4'd4
  } tile_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_COPY,
    S_DONE
  } arbState_t;

endpackage

// File: rtl/board_write_arbiter_if.sv
// Game-writer request/grant channel into the board write arbiter.
// The requester holds req/addr/data stable until it sees grant.
// Grant is combinational and only ever given while no reload is running.
interface board_write_arbiter_if import board_write_arbiter_pkg::*; #(
  parameter int ADDR_W = BOARD_ADDR_W,
  parameter int DATA_W = BOARD_DATA_W
);
  logic              gw_req;
  logic [ADDR_W-1:0] gw_addr;
  logic [DATA_W-1:0] gw_data;
  logic              gw_grant;

  // game writer side
  modport master (output gw_req, output gw_addr, output gw_data, input gw_grant);
  // arbiter side
  modport slave  (input gw_req, input gw_addr, input gw_data, output gw_grant);
endinterface

// File: rtl/board_write_arbiter_reload_addr_gen.sv
// Read/write pointer pair for the ROM-to-RAM board copy.
// Read pointer runs one cell ahead of the write pointer to cover ROM latency.
// lastCell flags the write of the final board cell; pointers never wrap.
module reload_addr_gen #(
  parameter int NUM_CELLS = 768,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ptrClear,
  input  logic              ptrPrime,
  input  logic              ptrAdvance,
  output logic [ADDR_W-1:0] rdPtr,
  output logic [ADDR_W-1:0] wrPtr,
  output logic              lastCell
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

  // Prime moves only the read side; advance moves both together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (ptrClear) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (ptrPrime) begin
      rdPtr <= rdPtr + ADDR_W'(1);
    end else if (ptrAdvance) begin
      rdPtr <= rdPtr + ADDR_W'(1);
      wrPtr <= wrPtr + ADDR_W'(1);
    end
  end

  assign lastCell = (wrPtr == LAST_ADDR);
endmodule

// File: rtl/board_write_arbiter.sv
// Owns the board RAM write port: ROM-to-RAM reload sequencer plus game-writer arbitration.
// Reload writes cell 0 two cycles after start, one cell per cycle; game writes land same cycle.
// Reload has absolute priority; game requests simply wait (unbuffered) until grant returns.
module board_write_arbiter import board_write_arbiter_pkg::*; #(
  parameter int                NUM_CELLS      = BOARD_NUM_CELLS,
  parameter int                ADDR_W         = BOARD_ADDR_W,
  parameter int                DATA_W         = BOARD_DATA_W,
  parameter int                CNT_W          = BOARD_CNT_W,
  parameter logic [DATA_W-1:0] TILE_FOOD_CODE = DATA_W'(TILE_FOOD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload_start,
  output logic                  reload_busy,
  output logic                  reload_done,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  board_write_arbiter_if.slave  gw,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic [CNT_W-1:0]      food_count
);

  // A board larger than the address space would need wrapping pointers.
  if (NUM_CELLS > (2 ** ADDR_W)) begin : g_bad_geometry
    $error("board_write_arbiter: NUM_CELLS does not fit in ADDR_W address bits");
  end

  arbState_t         stateQ;
  arbState_t         stateD;
  logic              ptrClear;
  logic              ptrPrime;
  logic              ptrAdvance;
  logic              lastCell;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] wrPtr;
  logic              foodHit;

  reload_addr_gen #(
    .NUM_CELLS (NUM_CELLS),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .ptrClear   (ptrClear),
    .ptrPrime   (ptrPrime),
    .ptrAdvance (ptrAdvance),
    .rdPtr      (rdPtr),
    .wrPtr      (wrPtr),
    .lastCell   (lastCell)
  );

  // Next-state decode and write-port mux; the game writer only reaches RAM from idle.
  always_comb begin
    stateD      = stateQ;
    ptrClear    = 1'b0;
    ptrPrime    = 1'b0;
    ptrAdvance  = 1'b0;
    rom_addr    = '0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    gw.gw_grant = 1'b0;
    case (stateQ)
      S_IDLE: begin
        gw.gw_grant = gw.gw_req;
        mem_we      = gw.gw_req;
        mem_addr    = gw.gw_addr;
        mem_data    = gw.gw_data;
        if (reload_start) begin
          stateD   = S_PRIME;
          ptrClear = 1'b1;
        end
      end
      S_PRIME: begin
        rom_addr = rdPtr;
        ptrPrime = 1'b1;
        stateD   = S_COPY;
      end
      S_COPY: begin
        mem_we     = 1'b1;
        mem_addr   = wrPtr;
        mem_data   = rom_data;
        rom_addr   = rdPtr;
        ptrAdvance = 1'b1;
        if (lastCell) begin
          stateD = S_DONE;
        end
      end
      S_DONE: begin
        stateD = S_IDLE;
      end
      default: begin
        stateD = S_IDLE;
      end
    endcase
  end

  // State register; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ      <= S_IDLE;
      reload_busy <= 1'b0;
      reload_done <= 1'b0;
    end else begin
      stateQ      <= stateD;
      reload_busy <= (stateD != S_IDLE);
      reload_done <= (stateD == S_DONE);
    end
  end

  assign foodHit = (stateQ == S_COPY) && (rom_data == TILE_FOOD_CODE);

  // Food tally for the current reload: cleared when a reload is accepted, saturating.
  always_ff @(posedge clk) begin
    if (!reset) begin
      food_count <= '0;
    end else if ((stateQ == S_IDLE) && reload_start) begin
      food_count <= '0;
    end else if (foodHit && (food_count != {CNT_W{1'b1}})) begin
      food_count <= food_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_board_write_arbiter.sv
// Bench for board_write_arbiter: directed reload / game-writer scenarios.
// A cycle-indexed reference model predicts every output each cycle from the reload start cycle.
// Literal checks pin key cycle numbers and food totals independently of the model.
module tb_board_write_arbiter;
  import board_write_arbiter_pkg::*;

  localparam int NC       = 768;
  localparam int SAT      = 511;
  localparam int DONE_REL = NC + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       reload_start;
  logic       reload_busy;
  logic       reload_done;
  logic [9:0] rom_addr;
  logic [3:0] rom_data;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [3:0] mem_data;
  logic [8:0] food_count;

  board_write_arbiter_if gwIf ();

  board_write_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .reload_start (reload_start),
    .reload_busy  (reload_busy),
    .reload_done  (reload_done),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .gw           (gwIf),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .food_count   (food_count)
  );

  always #5 clk = ~clk;

  int compared    = 0;
  int mismatched  = 0;
  int cyc         = 0;
  int romMode     = 0;
  int pre [0:NC];
  int relStart    = -1;
  int heldFood    = 0;
  bit modelValid  = 1'b0;
  int doneCnt     = 0;
  int lastDoneCyc = -1;

  function automatic logic [3:0] romTile(input int a);
    if (romMode == 1) return 4'(TILE_FOOD);
    return 4'(a % 16);
  endfunction

  task automatic setMode(input int m);
    romMode = m;
    pre[0] = 0;
    for (int i = 0; i < NC; i++) pre[i+1] = pre[i] + ((romTile(i) == 4'(TILE_FOOD)) ? 1 : 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Board ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= romTile(int'(rom_addr));

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and per-cycle compare.
  always @(negedge clk) begin : cmpProc
    int n;
    int rel;
    int k;
    int f;
    bit busyE;
    n     = cyc;
    rel   = (relStart >= 0) ? (n - relStart) : -1;
    busyE = (rel >= 1) && (rel <= DONE_REL);
    if ((relStart >= 0) && (n > relStart)) begin
      k = n - relStart - 2;
      if (k < 0) k = 0;
      if (k > NC) k = NC;
      f = pre[k];
      if (f > SAT) f = SAT;
    end else begin
      f = heldFood;
    end
    if (modelValid) begin
      check("reload_busy", 32'(reload_busy), 32'(busyE));
      check("reload_done", 32'(reload_done), 32'(rel == DONE_REL));
      if (busyE) begin
        check("gw_grant_blocked", 32'(gwIf.gw_grant), 32'(0));
        if ((rel >= 2) && (rel <= NC + 1)) begin
          check("copy_we", 32'(mem_we), 32'(1));
          check("copy_addr", 32'(mem_addr), 32'(rel - 2));
          check("copy_data", 32'(mem_data), 32'(romTile(rel - 2)));
        end else begin
          check("nocopy_we", 32'(mem_we), 32'(0));
        end
        if (rel <= NC) check("rom_addr", 32'(rom_addr), 32'(rel - 1));
      end else begin
        check("idle_grant", 32'(gwIf.gw_grant), 32'(gwIf.gw_req));
        check("idle_we", 32'(mem_we), 32'(gwIf.gw_req));
        if (gwIf.gw_req === 1'b1) begin
          check("idle_addr", 32'(mem_addr), 32'(gwIf.gw_addr));
          check("idle_data", 32'(mem_data), 32'(gwIf.gw_data));
        end
        check("idle_rom_addr", 32'(rom_addr), 32'(0));
      end
      check("food_count", 32'(food_count), 32'(f));
      if (reload_done === 1'b1) begin
        doneCnt++;
        lastDoneCyc = n;
      end
    end
    if ((relStart >= 0) && (rel >= DONE_REL)) begin
      heldFood = f;
      relStart = -1;
    end
    if (reset !== 1'b1) begin
      relStart   = -1;
      heldFood   = 0;
      modelValid = 1'b1;
    end else if ((reload_start === 1'b1) && !busyE) begin
      relStart = n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) tick(1);
  endtask

  initial begin
    int s;
    int waited;
    int grantCyc;
    bit granted;
    reset = 1'b0;
    reload_start = 1'b0;
    gwIf.gw_req  = 1'b0;
    gwIf.gw_addr = '0;
    gwIf.gw_data = '0;
    setMode(0);
    tick(3);
    reset = 1'b1;
    tick(2);

    // reset state
    #3;
    check("rst_busy", 32'(reload_busy), 32'(0));
    check("rst_done", 32'(reload_done), 32'(0));
    check("rst_food", 32'(food_count), 32'(0));
    check("rst_rom_addr", 32'(rom_addr), 32'(0));
    tick(1);

    // idle game write goes straight through
    gwIf.gw_req  = 1'b1;
    gwIf.gw_addr = 10'd495;
    gwIf.gw_data = 4'(TILE_PACMAN);
    #3;
    check("gw495_grant", 32'(gwIf.gw_grant), 32'(1));
    check("gw495_we", 32'(mem_we), 32'(1));
    check("gw495_addr", 32'(mem_addr), 32'(495));
    check("gw495_data", 32'(mem_data), 32'(3));
    tick(1);
    gwIf.gw_req = 1'b0;
    tick(2);

    // full reload, repeated start ignored, game request held through it
    reload_start = 1'b1;
    s = cyc;
    tick(1);
    reload_start = 1'b0;
    #3;
    check("prime_busy", 32'(reload_busy), 32'(1));
    check("prime_we", 32'(mem_we), 32'(0));
    waitCyc(s + 2);
    #3;
    check("first_we", 32'(mem_we), 32'(1));
    check("first_addr", 32'(mem_addr), 32'(0));
    waitCyc(s + 50);
    reload_start = 1'b1;
    tick(1);
    reload_start = 1'b0;
    waitCyc(s + 100);
    gwIf.gw_req  = 1'b1;
    gwIf.gw_addr = 10'd100;
    gwIf.gw_data = 4'(TILE_GHOST);
    granted  = 1'b0;
    grantCyc = -1;
    waited   = 0;
    while (!granted && (waited < 2000)) begin
      #3;
      if (gwIf.gw_grant === 1'b1) begin
        granted  = 1'b1;
        grantCyc = cyc;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    gwIf.gw_req = 1'b0;
    check("held_req_granted", 32'(granted), 32'(1));
    check("held_req_grant_cycle", 32'(grantCyc), 32'(s + 771));
    check("reload1_done_count", 32'(doneCnt), 32'(1));
    check("reload1_done_cycle", 32'(lastDoneCyc), 32'(s + 770));
    check("reload1_food", 32'(food_count), 32'(48));
    tick(3);

    // reset mid-reload aborts without a done pulse
    reload_start = 1'b1;
    s = cyc;
    tick(1);
    reload_start = 1'b0;
    waitCyc(s + 300);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    #3;
    check("abort_food", 32'(food_count), 32'(0));
    check("abort_busy", 32'(reload_busy), 32'(0));
    tick(500);
    check("abort_no_done", 32'(doneCnt), 32'(1));

    // simultaneous game request and reload start: write granted, reload follows
    gwIf.gw_req  = 1'b1;
    gwIf.gw_addr = 10'd7;
    gwIf.gw_data = 4'(TILE_WALL);
    reload_start = 1'b1;
    s = cyc;
    #3;
    check("both_grant", 32'(gwIf.gw_grant), 32'(1));
    check("both_addr", 32'(mem_addr), 32'(7));
    tick(1);
    gwIf.gw_req  = 1'b0;
    reload_start = 1'b0;
    #3;
    check("both_busy_next", 32'(reload_busy), 32'(1));
    waitCyc(s + 775);
    check("reload2_done_count", 32'(doneCnt), 32'(2));
    check("reload2_done_cycle", 32'(lastDoneCyc), 32'(s + 770));
    check("reload2_food", 32'(food_count), 32'(48));

    // all-food board saturates the counter
    setMode(1);
    reload_start = 1'b1;
    s = cyc;
    tick(1);
    reload_start = 1'b0;
    waitCyc(s + 102);
    #3;
    check("sat_food_partial", 32'(food_count), 32'(100));
    waitCyc(s + 775);
    check("sat_food_final", 32'(food_count), 32'(511));
    check("reload3_done_count", 32'(doneCnt), 32'(3));
    check("reload3_done_cycle", 32'(lastDoneCyc), 32'(s + 770));
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
